// File: rtl/sm_keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sm_keypad_pkg                                             |
// | Purpose  : Shared constants for the matrix keypad scanner: key code  |
// |            width, committed-state "no key" encoding and FSM state    |
// |            encoding.                                                 |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package sm_keypad_pkg;

   localparam int KEY_W    = 4;
   localparam int COMMIT_W = KEY_W + 1;

   // Committed key: MSB set means no key is committed; low bits are the index.
   typedef logic [COMMIT_W-1:0] commit_t;
   localparam commit_t KEY_NONE = {1'b1, {KEY_W{1'b0}}};

   localparam int STATE_W = 1;
   localparam logic [STATE_W-1:0] S_SCAN = 1'b0;
   localparam logic [STATE_W-1:0] S_EVAL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sm_keypad_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sm_keypad_debounce                                        |
// | Purpose  : Whole-frame debouncer. On each eval strobe it compares    |
// |            the new frame with the previous one, tracks a saturating  |
// |            stability count, and commits single-key presses (and     |
// |            releases when SM_KEYPAD_RELEASE_EN is defined).           |
// | Ports    : clk, rst        - clock, synchronous active-high reset    |
// |            i_eval          - one-cycle strobe, frame complete        |
// |            i_frame         - pressed bitmap, bit = row*COLS+col      |
// |            o_evt_valid     - event raised this cycle (comb)          |
// |            o_evt_code      - key index of the raised event           |
// |            o_evt_release   - event is a release (macro only)         |
// |            o_key_down      - a debounced single key is held          |
// | Macro    : SM_KEYPAD_RELEASE_EN                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sm_keypad_debounce
   import sm_keypad_pkg::*;
#(
   parameter int NKEYS    = 16,
   parameter int DEBOUNCE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_eval,
   input  logic [NKEYS-1:0] i_frame,
   output logic             o_evt_valid,
   output logic [KEY_W-1:0] o_evt_code,
`ifdef SM_KEYPAD_RELEASE_EN
   output logic             o_evt_release,
`endif
   output logic             o_key_down
);

   localparam int SW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam int PW = $clog2(NKEYS + 1);
   localparam logic [SW-1:0] c_stable_max = SW'(DEBOUNCE - 1);

   logic [NKEYS-1:0] r_prev;
   logic [SW-1:0]    r_stable;
   commit_t          r_committed;
   logic             r_key_down;

   logic [SW-1:0]    w_stable_nxt;
   logic [PW-1:0]    w_pop;
   logic [KEY_W-1:0] w_idx;
   logic             w_at_thr;
   logic             w_press;
   logic             w_release;

   // Popcount plus index of the highest set bit; the index is only used
   // when exactly one bit is set, so the priority order is irrelevant.
   always_comb begin
      w_pop = '0;
      w_idx = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (i_frame[i]) begin
            w_pop = w_pop + PW'(1);
            w_idx = KEY_W'(i);
         end
      end
   end

   always_comb begin
      w_stable_nxt = '0;
      if (i_frame == r_prev) begin
         w_stable_nxt = (r_stable == c_stable_max) ? r_stable : r_stable + SW'(1);
      end
   end

   // Commit condition is re-evaluated on every eval while saturated, so a
   // held key keeps re-qualifying; the "differs from committed" term keeps
   // that from producing repeat presses.
   assign w_at_thr  = i_eval && (w_stable_nxt == c_stable_max);
   assign w_press   = w_at_thr && (w_pop == PW'(1)) && (r_committed != {1'b0, w_idx});
   assign w_release = w_at_thr && (w_pop == '0) && !r_committed[KEY_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev      <= '0;
         r_stable    <= '0;
         r_committed <= KEY_NONE;
         r_key_down  <= 1'b0;
      end else if (i_eval) begin
         r_prev   <= i_frame;
         r_stable <= w_stable_nxt;
         if (w_press) begin
            r_committed <= {1'b0, w_idx};
            r_key_down  <= 1'b1;
         end else if (w_release) begin
            r_committed <= KEY_NONE;
            r_key_down  <= 1'b0;
         end
      end
   end

`ifdef SM_KEYPAD_RELEASE_EN
   assign o_evt_valid   = w_press | w_release;
   assign o_evt_code    = w_press ? w_idx : r_committed[KEY_W-1:0];
   assign o_evt_release = w_release;
`else
   assign o_evt_valid   = w_press;
   assign o_evt_code    = w_idx;
`endif
   assign o_key_down = r_key_down;

endmodule
`default_nettype wire

// File: rtl/sm_keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sm_keypad_scan                                            |
// | Purpose  : ROWS x COLS matrix keypad scanner. Drives one row low at  |
// |            a time, samples columns through a 2-flop synchronizer,    |
// |            debounces whole frames and presents key events on a       |
// |            one-deep valid/ready register.                            |
// | Ports    : clk, rst     - clock, synchronous active-high reset       |
// |            col_n        - raw column pins, active-low                |
// |            row_n        - row drive, active-low, one-hot-zero        |
// |            key_code     - event key index (row*COLS+col)             |
// |            key_release  - event is a release (0 without macro)       |
// |            key_valid    - event available                            |
// |            key_ready    - consumer accepts the event                 |
// |            key_down     - debounced single key currently held        |
// |            overflow     - sticky, an event was dropped               |
// | Macro    : SM_KEYPAD_RELEASE_EN enables release events               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sm_keypad_scan
   import sm_keypad_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COLS-1:0]  col_n,
   output logic [ROWS-1:0]  row_n,
   output logic [KEY_W-1:0] key_code,
   output logic             key_release,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_down,
   output logic             overflow
);

   localparam int NKEYS = ROWS * COLS;
   localparam int DW    = $clog2(SCAN_DIV);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [DW-1:0]   c_dwell_last = DW'(SCAN_DIV - 1);
   localparam logic [RW-1:0]   c_row_last   = RW'(ROWS - 1);
   localparam logic [ROWS-1:0] c_row_n_rst  = ~ROWS'(1);

   logic [COLS-1:0]    r_sync1;
   logic [COLS-1:0]    r_sync2;
   logic [DW-1:0]      r_dwell;
   logic [RW-1:0]      r_row;
   logic [ROWS-1:0]    r_row_n;
   logic [NKEYS-1:0]   r_frame;
   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic               w_eval;
   logic               w_dwell_end;
   logic [COLS-1:0]    w_cols;

   logic               w_evt_valid;
   logic [KEY_W-1:0]   w_evt_code;
   logic               w_evt_load;
   logic [KEY_W-1:0]   r_key_code;
   logic               r_key_valid;
   logic               r_overflow;

   // ---------------- column synchronizer ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= col_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_cols = ~r_sync2;

   // ---------------- row scan ----------------
   assign w_dwell_end = (r_dwell == c_dwell_last);

   // row_n is registered from r_row, so the pins follow the index one cycle
   // later; sampling at the end of the dwell still leaves settling margin.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dwell <= '0;
         r_row   <= '0;
         r_row_n <= c_row_n_rst;
      end else begin
         r_dwell <= w_dwell_end ? '0 : r_dwell + DW'(1);
         if (w_dwell_end) begin
            r_row <= (r_row == c_row_last) ? '0 : r_row + RW'(1);
         end
         for (int r = 0; r < ROWS; r++) begin
            r_row_n[r] <= (RW'(r) != r_row);
         end
      end
   end

   // Frame is cleared in EVAL; the next row write is at least SCAN_DIV-1
   // cycles away, so the two never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
      end else if (w_eval) begin
         r_frame <= '0;
      end else if (w_dwell_end) begin
         for (int r = 0; r < ROWS; r++) begin
            if (RW'(r) == r_row) begin
               r_frame[r*COLS +: COLS] <= w_cols;
            end
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_SCAN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SCAN:  if (w_dwell_end && (r_row == c_row_last)) w_state_nxt = S_EVAL;
         S_EVAL:  w_state_nxt = S_SCAN;
         default: w_state_nxt = S_SCAN;
      endcase
   end

   always_comb begin
      w_eval = 1'b0;
      if (r_state == S_EVAL) w_eval = 1'b1;
   end

   // ---------------- debouncer ----------------
`ifdef SM_KEYPAD_RELEASE_EN
   logic w_evt_release;
   logic r_key_release;
`endif

   sm_keypad_debounce #(
      .NKEYS    (NKEYS),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk           (clk),
      .rst           (rst),
      .i_eval        (w_eval),
      .i_frame       (r_frame),
      .o_evt_valid   (w_evt_valid),
      .o_evt_code    (w_evt_code),
`ifdef SM_KEYPAD_RELEASE_EN
      .o_evt_release (w_evt_release),
`endif
      .o_key_down    (key_down)
   );

   // ---------------- event register ----------------
   // A new event may overwrite the register only when it is empty or being
   // drained this very cycle; otherwise it is dropped and flagged.
   assign w_evt_load = w_evt_valid && (!r_key_valid || key_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_evt_valid) begin
         if (w_evt_load) begin
            r_key_code  <= w_evt_code;
            r_key_valid <= 1'b1;
         end else begin
            r_overflow  <= 1'b1;
         end
      end else if (r_key_valid && key_ready) begin
         r_key_valid <= 1'b0;
      end
   end

`ifdef SM_KEYPAD_RELEASE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_release <= 1'b0;
      end else if (w_evt_load) begin
         r_key_release <= w_evt_release;
      end
   end
   assign key_release = r_key_release;
`else
   assign key_release = 1'b0;
`endif

   assign row_n     = r_row_n;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sm_keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sm_keypad_scan                                         |
// | Purpose  : Self-checking bench for sm_keypad_scan with a behavioural |
// |            keypad matrix model and an expected-event scoreboard.     |
// | Macro    : SM_KEYPAD_RELEASE_EN selects release-event expectations  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sm_keypad_scan;

`ifdef SM_KEYPAD_RELEASE_EN
   localparam logic c_rel = 1'b1;
`else
   localparam logic c_rel = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_release;
   logic       key_valid;
   logic       key_ready;
   logic       key_down;
   logic       overflow;

   logic [15:0] keys;
   logic [5:0]  exp_q[$];
   logic [5:0]  mon_exp;
   int          n_cmp;
   int          n_err;
   int          n_evt;
   int          evt0;
   int          cyc;

   always #5 clk = ~clk;

   sm_keypad_scan #(
      .ROWS     (4),
      .COLS     (4),
      .SCAN_DIV (4),
      .DEBOUNCE (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_n       (col_n),
      .row_n       (row_n),
      .key_code    (key_code),
      .key_release (key_release),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_down    (key_down),
      .overflow    (overflow)
   );

   // Keypad matrix: a pressed key shorts its column to its row when that
   // row is driven low.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (row_n[r] === 1'b0 && keys[r*4+c]) col_n[c] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted event is matched against the queue head;
   // an empty queue yields an expectation that can never match.
   always @(negedge clk) begin
      if (rst === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1) begin
         mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h00;
         n_evt++;
         check("event", {26'd0, 1'b1, key_release, key_code}, {26'd0, mon_exp});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_keys(input logic [15:0] k);
      @(posedge clk);
      #1 keys = k;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 key_ready = v;
   endtask

   task automatic wait_valid(input int max, output int cnt);
      cnt = 0;
      while (cnt < max && key_valid !== 1'b1) begin
         @(negedge clk);
         cnt++;
      end
      check("valid_seen", {31'd0, key_valid}, 32'd1);
   endtask

   task automatic wait_row(input logic [3:0] pat);
      int n = 0;
      while (n < 40 && row_n !== pat) begin
         @(negedge clk);
         n++;
      end
      check("row_seen", {28'd0, row_n}, {28'd0, pat});
   endtask

   initial begin
      n_cmp = 0; n_err = 0; n_evt = 0;
      rst = 1'b1; key_ready = 1'b1; keys = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_row_n",   {28'd0, row_n}, 32'hE);
      check("rst_valid",   {31'd0, key_valid}, 32'd0);
      check("rst_code",    {28'd0, key_code}, 32'd0);
      check("rst_release", {31'd0, key_release}, 32'd0);
      check("rst_down",    {31'd0, key_down}, 32'd0);
      check("rst_ovf",     {31'd0, overflow}, 32'd0);

      // 1: single key 9 pressed just after row 2 was sampled
      wait_row(4'b0111);
      exp_q.push_back({1'b1, 1'b0, 4'd9});
      set_keys(16'h0200);
      wait_valid(200, cyc);
      check("t1_latency_ge48", {31'd0, cyc >= 48}, 32'd1);
      check("t1_code", {28'd0, key_code}, 32'd9);
      check("t1_down", {31'd0, key_down}, 32'd1);
      @(negedge clk);
      check("t1_pulse", {31'd0, key_valid}, 32'd0);

      // 5: release of key 9
      if (c_rel) exp_q.push_back({1'b1, 1'b1, 4'd9});
      set_keys(16'h0000);
      tick(100);
      check("t5_down", {31'd0, key_down}, 32'd0);
      check("t5_queue", exp_q.size(), 32'd0);

      // 2: bounce on key 5, then steady press
      evt0 = n_evt;
      for (int i = 0; i < 10; i++) begin
         set_keys(keys ^ 16'h0020);
         tick(19);
      end
      check("t2_bounce_no_evt", n_evt, evt0);
      check("t2_bounce_down", {31'd0, key_down}, 32'd0);
      exp_q.push_back({1'b1, 1'b0, 4'd5});
      set_keys(16'h0020);
      wait_valid(200, cyc);
      tick(64);
      check("t2_one_evt", n_evt, evt0 + 1);
      check("t2_down", {31'd0, key_down}, 32'd1);

      // 3: chord 0+15 added while 5 is held
      evt0 = n_evt;
      set_keys(16'h8021);
      tick(160);
      check("t3_no_evt", n_evt, evt0);
      check("t3_down_held", {31'd0, key_down}, 32'd1);
      if (c_rel) exp_q.push_back({1'b1, 1'b1, 4'd5});
      set_keys(16'h0000);
      tick(100);
      check("t3_down_clr", {31'd0, key_down}, 32'd0);
      check("t3_queue", exp_q.size(), 32'd0);

      // 4: back-pressure
      set_ready(1'b0);
      exp_q.push_back({1'b1, 1'b0, 4'd3});
      set_keys(16'h0008);
      wait_valid(200, cyc);
      check("t4_code", {28'd0, key_code}, 32'd3);
      check("t4_rel", {31'd0, key_release}, 32'd0);
      set_keys(16'h0000);
      tick(100);
      check("t4_ovf_mid", {31'd0, overflow}, {31'd0, c_rel});
      set_keys(16'h0080);
      tick(100);
      check("t4_valid_held", {31'd0, key_valid}, 32'd1);
      check("t4_code_held", {28'd0, key_code}, 32'd3);
      check("t4_ovf", {31'd0, overflow}, 32'd1);
      check("t4_down7", {31'd0, key_down}, 32'd1);
      set_ready(1'b1);
      tick(2);
      check("t4_drained", {31'd0, key_valid}, 32'd0);
      check("t4_queue", exp_q.size(), 32'd0);
      if (c_rel) exp_q.push_back({1'b1, 1'b1, 4'd7});
      set_keys(16'h0000);
      tick(100);
      check("t4_down_clr", {31'd0, key_down}, 32'd0);

      // 6: reset while an event is pending and row 2 is driven
      set_ready(1'b0);
      set_keys(16'h0200);
      wait_valid(200, cyc);
      wait_row(4'b1101);
      wait_row(4'b1011);
      @(posedge clk);
      #1 rst = 1'b1; keys = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_row_n",   {28'd0, row_n}, 32'hE);
      check("t6_valid",   {31'd0, key_valid}, 32'd0);
      check("t6_code",    {28'd0, key_code}, 32'd0);
      check("t6_release", {31'd0, key_release}, 32'd0);
      check("t6_down",    {31'd0, key_down}, 32'd0);
      check("t6_ovf",     {31'd0, overflow}, 32'd0);
      evt0 = n_evt;
      set_ready(1'b1);
      tick(100);
      check("t6_no_evt", n_evt, evt0);
      check("final_queue", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sm_keypad_scan.md
Name: sm_keypad_scan

Overview:
- Input-side counterpart of the multiplexed 7-segment driver: scans a ROWS x COLS matrix keypad on GPIO.
- Drives one row low at a time and samples the columns through a synchronizer.
- Debounces whole-frame snapshots and emits single-key press events to the core on a valid/ready handshake.
- Sits on the board top between GPIO pins and sm_top extraInput or a memory-mapped input register.

Parameters:
- ROWS, 4, keypad rows; ROWS*COLS must be <= 16.
- COLS, 4, keypad columns.
- SCAN_DIV, 1000, clk cycles each row is held active (the dwell); must be >= 4.
- DEBOUNCE, 8, consecutive identical frames required before a commit; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- col_n  in  COLS  raw column pins, active-low (pulled up externally).
- row_n  out  ROWS  row drive, active-low, one-hot-zero.
- key_code  out  4  key index = row*COLS + col.
- key_release  out  1  1 = release event; tied 0 without the optional feature.
- key_valid  out  1  event available.
- key_ready  in  1  consumer accepts the event.
- key_down  out  1  level: a debounced single key is currently held.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset values:
  - row_n = all ones except bit 0 = 0.
  - row index = 0, dwell counter = 0.
  - synchronizer flops = all ones.
  - frame and previous-frame snapshots = 0.
  - stable_cnt = 0, committed state = none.
  - key_code = 0, key_release = 0, key_valid = 0, key_down = 0, overflow = 0.
- Reset mid-scan or mid-handshake aborts everything; any pending event is lost.
- Synchronizer: col_n passes through 2 flops, then is inverted, giving pressed = 1.
- Dwell counter counts 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, the synchronized columns are written into the frame snapshot at bits [row*COLS +: COLS].
  - On the same cycle the row index advances and wraps ROWS-1 -> 0.
  - row_n updates the following cycle.
  - Sampling at the end of the dwell gives >= SCAN_DIV-3 cycles of settling after synchronizer delay.
- FSM:
  - SCAN: normal scanning.
  - EVAL: one cycle, entered on the cycle after row ROWS-1 is sampled. Scanning of row 0 continues in parallel, with the dwell counter not stalled. Returns to SCAN.
- EVAL actions:
  - If frame == previous frame: stable_cnt increments, saturating at DEBOUNCE-1. Otherwise stable_cnt = 0.
  - previous frame <= frame; frame cleared.
  - Commit happens when stable_cnt reaches DEBOUNCE-1. It fires on the first eval where this becomes true, and again on later evals while it stays there.
    - Popcount == 1 and the key differs from committed: committed = key, key_down = 1, press event raised.
    - Popcount == 0 and committed != none: committed = none, key_down = 0, release event raised only with the optional feature.
    - Popcount >= 2 (ghosting/chord): no change; committed state and key_down are held.
- Event output register (one deep):
  - A raised event loads key_code / key_release and sets key_valid on the cycle after EVAL.
  - key_valid holds, with data stable, until key_valid & key_ready. It is then cleared the next cycle.
  - New event with key_valid=1 and key_ready=0: the event is dropped, the register is unchanged, and overflow <= 1. overflow clears only on rst.
  - New event on the same cycle as key_valid & key_ready: the new event is loaded and key_valid stays 1. No overflow.
- Key index width is fixed at 4 bits; unused codes never appear.
- Direct 1->2->1 key transitions (A held, B added, B released) produce no new press, because A is already committed.

Optional Feature:
- Macro SM_KEYPAD_RELEASE_EN.
- Defined: releases generate events with key_release = 1 and key_code = the released key's index.
- Undefined:
  - Releases only clear the committed state and key_down.
  - key_release is constant 0.
  - Release-event logic is not synthesized.

Decomposition:
- Shared package (sm_keypad_pkg):
  - FSM state encoding (S_SCAN, S_EVAL).
  - Key code width constant KEY_W = 4.
  - "No key" committed-state encoding (5-bit committed value, MSB = none).
- One sub-module: sm_keypad_debounce, containing the previous-frame compare, stable_cnt, popcount/one-hot-to-index and commit logic.
- The top module keeps the synchronizer, scan counter and event register.

Test Plan:
1. Press, single key.
   - Stimulus: SCAN_DIV=4, DEBOUNCE=3. Release rst, then hold col_n[1]=0 whenever row_n[2]=0. key_ready=1.
   - Required response: key_valid pulses for one cycle with key_code=9, no earlier than 3 full 16-cycle frames after the press. key_down=1.
2. Bounce rejection.
   - Stimulus: key 5 toggled every 20 cycles for 200 cycles.
   - Required response: no key_valid. Then hold steady: exactly one event, code 5.
3. Ghost/chord.
   - Stimulus: keys 0 and 15 pressed simultaneously for 10 frames.
   - Required response: no event; key_down unchanged.
4. Back-pressure.
   - Stimulus: key_ready=0. Press key 3, release, press key 7.
   - Required response: key_valid=1 with code 3 held stable; overflow=1 after the key-7 press. Assert ready: code 3 consumed, key_valid=0.
5. Release event.
   - With SM_KEYPAD_RELEASE_EN: releasing key 9 after test 1 gives an event with key_release=1, code 9, key_down=0.
   - Without the macro: no event, key_down=0.
6. Reset mid-scan.
   - Stimulus: assert rst for 1 cycle while key_valid=1 and row 2 is active.
   - Required response: next cycle all outputs are at reset values and row_n = 4'b1110.
